seven_segment_reader: RTL and testbench

Recovers BCD digits from a multiplexed, active-high seven-segment display bus. This is the return path for the segment decoders: it samples the digit strobe and segment lines, qualifies each digit over consecutive identical samples, and converts each pattern back to a 4-bit code. Once every digit has been captured, it presents a complete frame on a valid/ready handshake. Self-check benches and display-loopback paths use it to confirm what the display actually shows.

---
 rtl/seven_segment_reader.sv | 90 +++++++++
 tb/tb_seven_segment_reader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers BCD digits from a multiplexed seven-segment bus and
// presents each fully captured scan as a frame on a valid/ready handshake.
module seven_segment_reader #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   input  logic                    frame_ready,
   output logic                    frame_valid,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    overrun
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

   logic [NUM_DIGITS-1:0]   sel_q, sel_p, mask, slot_err;
   logic [6:0]              seg_q, seg_p;
   logic [CW-1:0]           cnt, cnt_nx;
   logic [4*NUM_DIGITS-1:0] slot;
   logic [3:0]              code;
   logic                    one_hot, same, accept, full, bad;

   always_comb begin
      one_hot = sel_q != '0 && (sel_q & (sel_q - NUM_DIGITS'(1))) == '0;
      same    = {sel_q, seg_q} == {sel_p, seg_p};
      cnt_nx  = !one_hot ? '0 : same ? (cnt == SAT ? SAT : cnt + CW'(1)) : CW'(1);
      // a dwell already saturated on this same pair must not accept again
      accept  = one_hot && cnt_nx == SAT && !(same && cnt == SAT);
      full    = &mask;
   end

   always_comb begin
      case (seg_q)
         7'b1111110: code = 4'h0;
         7'b0110000: code = 4'h1;
         7'b1101101: code = 4'h2;
         7'b1111001: code = 4'h3;
         7'b0110011: code = 4'h4;
         7'b1011011: code = 4'h5;
         7'b1011111: code = 4'h6;
         7'b1110000: code = 4'h7;
         7'b1111111: code = 4'h8;
         7'b1111011: code = 4'h9;
         7'b0000001: code = 4'hA;
         7'b0000000: code = 4'hF;
         default:    code = 4'hE;
      endcase
      bad = code == 4'hE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q       <= '0;
         seg_q       <= '0;
         sel_p       <= '0;
         seg_p       <= '0;
         cnt         <= '0;
         mask        <= '0;
         slot        <= '0;
         slot_err    <= '0;
         frame_valid <= 1'b0;
         bcd_out     <= '0;
         digit_err   <= '0;
         overrun     <= 1'b0;
      end else begin
         sel_q <= dig_sel;
         seg_q <= seg;
         sel_p <= sel_q;
         seg_p <= seg_q;
         cnt   <= cnt_nx;
         for (int i = 0; i < NUM_DIGITS; i++)
            if (accept && sel_q[i]) begin
               slot[4*i+:4] <= code;
               slot_err[i]  <= bad;
            end
         mask    <= (full ? '0 : mask) | (accept ? sel_q : '0);
         overrun <= 1'b0;
         if (full && (!frame_valid || frame_ready)) begin
            frame_valid <= 1'b1;
            bcd_out     <= slot;
            digit_err   <= slot_err;
         end else if (full) overrun <= 1'b1;
         else if (frame_valid && frame_ready) frame_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed scans with a scoreboard queue checked by a
// monitor on every frame handshake.
module tb_seven_segment_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = '0;
   logic [3:0]  dig_sel = '0;
   logic        frame_ready = 1'b1;
   logic        frame_valid, overrun;
   logic [15:0] bcd_out;
   logic [3:0]  digit_err;

   logic [6:0]  pat [0:9];
   logic [19:0] q [$];
   int          passed = 0, total = 0, ovr_seen = 0, exp_ovr = 0;

   seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .frame_ready(frame_ready),
      .frame_valid(frame_valid), .bcd_out(bcd_out), .digit_err(digit_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic hold(input logic [3:0] sel, input logic [6:0] s, input int n);
      @(negedge clk);
      dig_sel = sel;
      seg = s;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic scan(input logic [15:0] d);
      for (int i = 0; i < 4; i++) hold(4'(1 << i), pat[d[4*i+:4]], 6);
      hold(4'b0000, 7'b0, 4);
   endtask

   initial forever begin
      @(negedge clk);
      #1;
      if (overrun) ovr_seen++;
      if (frame_valid && frame_ready) begin
         if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_frame: got bcd_out %h digit_err %b, none expected", bcd_out, digit_err);
         end else begin
            logic [19:0] e;
            e = q.pop_front();
            chk("frame_bcd", 32'(bcd_out), 32'(e[19:4]));
            chk("frame_err", 32'(digit_err), 32'(e[3:0]));
         end
      end
   end

   initial begin
      pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
      pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
      pat[8] = 7'b1111111; pat[9] = 7'b1111011;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(frame_valid), 0);
      chk("rst_bcd", 32'(bcd_out), 0);
      chk("rst_err", 32'(digit_err), 0);
      chk("rst_overrun", 32'(overrun), 0);
      rst = 1'b0;

      // basic scan 1,2,3,4 with exact latency on the final digit
      q.push_back({16'h4321, 4'b0000});
      for (int i = 0; i < 3; i++) hold(4'(1 << i), pat[i + 1], 6);
      @(negedge clk);
      dig_sel = 4'b1000;
      seg = pat[4];
      repeat (5) @(posedge clk);
      #1 chk("latency_early", 32'(frame_valid), 0);
      @(posedge clk);
      #1 chk("latency_exact", 32'(frame_valid), 1);
      hold(4'b0000, 7'b0, 4);

      // glitch: 3-cycle dwell on slot 2 does not count
      q.push_back({16'h6789, 4'b0000});
      hold(4'b0001, pat[9], 6);
      hold(4'b0010, pat[8], 6);
      hold(4'b0100, pat[7], 3);
      hold(4'b1000, pat[6], 6);
      hold(4'b0000, 7'b0, 10);
      chk("glitch_no_frame", q.size(), 1);
      hold(4'b0100, pat[7], 6);
      hold(4'b0000, 7'b0, 4);
      chk("glitch_completed", q.size(), 0);

      // invalid, dash and blank patterns
      q.push_back({16'hFEA7, 4'b0100});
      hold(4'b0100, 7'b1010101, 6);
      hold(4'b0010, 7'b0000001, 6);
      hold(4'b1000, 7'b0000000, 6);
      hold(4'b0001, pat[7], 6);
      hold(4'b0000, 7'b0, 4);

      // strobe faults in the middle of a scan leave mask and slots alone
      q.push_back({16'h4321, 4'b0000});
      for (int i = 0; i < 3; i++) hold(4'(1 << i), pat[i + 1], 6);
      hold(4'b0011, pat[9], 10);
      hold(4'b0000, pat[9], 10);
      chk("strobe_no_frame", q.size(), 1);
      hold(4'b1000, pat[4], 6);
      hold(4'b0000, 7'b0, 4);

      // backpressure: second completion is dropped with one overrun pulse
      frame_ready = 1'b0;
      q.push_back({16'h8765, 4'b0000});
      scan(16'h8765);
      scan(16'h2109);
      exp_ovr = 1;
      chk("bp_valid", 32'(frame_valid), 1);
      chk("bp_bcd_held", 32'(bcd_out), 32'h8765);
      chk("bp_overrun", ovr_seen, exp_ovr);
      @(negedge clk);
      frame_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_drop_valid", 32'(frame_valid), 0);
      @(negedge clk);
      frame_ready = 1'b0;

      // async reset while a frame is pending and slot 3 is already captured
      scan(16'h4321);
      chk("pre_rst_pending", 32'(frame_valid), 1);
      hold(4'b1000, pat[5], 6);
      @(negedge clk);
      dig_sel = 4'b0001;
      seg = pat[6];
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(frame_valid), 0);
      chk("arst_bcd", 32'(bcd_out), 0);
      chk("arst_err", 32'(digit_err), 0);
      @(negedge clk);
      rst = 1'b0;
      frame_ready = 1'b1;
      dig_sel = 4'b0000;
      for (int i = 0; i < 3; i++) hold(4'(1 << i), pat[9], 6);
      hold(4'b0000, 7'b0, 10);
      chk("partial_no_frame", 32'(frame_valid), 0);
      q.push_back({16'h8765, 4'b0000});
      scan(16'h8765);

      hold(4'b0000, 7'b0, 10);
      chk("queue_drained", q.size(), 0);
      chk("overrun_total", ovr_seen, exp_ovr);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
